dm_access_unit: RTL and testbench

- Initiator side of the data-memory bus that the CPU's memory stage drives: m_data_addr, m_data_wdata, m_data_byteen, m_data_rdata, m_inst_addr.
- Takes one load/store request at a time from the pipeline over a valid/ready handshake.
- Builds the word-aligned bus access, waits on a memory ready signal, and sign/zero-extends load data.
- Returns a single response, flagging misaligned or out-of-range accesses instead of touching memory.

---
 rtl/dm_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// dm_access_unit: initiator side of the data-memory bus driven by the CPU
// memory stage. Accepts one load/store at a time, builds the word-aligned bus
// access, waits for mem_ready, extends load data and returns one response.
// Misaligned or out-of-range requests are answered with an exception code
// without any bus activity.
//
// Optional build macro: DM_ACCESS_TRACE_EN (simulation trace of committed
// stores and faulting accesses).
//
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready, req_op, req_addr, req_wdata, req_pc : request
//   resp_valid/resp_ready, resp_rdata, resp_exc             : response
//   m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr    : bus outputs
//   m_data_rdata, mem_ready                                  : bus inputs
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | read access on the bus, waiting for mem_ready
// STORE | write access on the bus, waiting for mem_ready
// RESP  | response presented, waiting for resp_ready
module dm_access_unit #(
   parameter logic [31:0] DM_BASE  = 32'h0000_0000,
   parameter int          DM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_exc,
   output logic [31:0] m_data_addr,
   output logic [31:0] m_data_wdata,
   output logic [3:0]  m_data_byteen,
   input  logic [31:0] m_data_rdata,
   input  logic        mem_ready,
   output logic [31:0] m_inst_addr
);

   typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   localparam logic [4:0]  EXC_ADEL = 5'd4;
   localparam logic [4:0]  EXC_ADES = 5'd5;
   localparam logic [32:0] DM_SPAN  = 33'(DM_WORDS) * 33'd4;

   state_t      state, state_nxt;
   logic [31:0] addr_q, wdata_q, pc_q, rdata_q;
   logic [2:0]  op_q;
   logic [4:0]  exc_q;

   logic        misalign, out_of_range, fault;
   logic [32:0] offset;
   logic [4:0]  fault_code;
   logic [3:0]  be_lanes;
   logic [31:0] wdata_lanes, load_ext;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   // The offset is computed one bit wider so an address below DM_BASE borrows
   // into bit 32 and fails the span compare; there is no wrap into range.
   always_comb begin
      misalign = 1'b0;
      case (req_op)
         OP_LW, OP_SW:          misalign = (req_addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH:  misalign = req_addr[0];
         default:               misalign = 1'b0;
      endcase
      offset       = {1'b0, req_addr} - {1'b0, DM_BASE};
      out_of_range = (offset >= DM_SPAN);
      fault        = misalign | out_of_range;
      fault_code   = (req_op >= OP_SW) ? EXC_ADES : EXC_ADEL;
   end

   always_comb begin
      be_lanes    = 4'b0000;
      wdata_lanes = wdata_q;
      case (op_q)
         OP_SW: be_lanes = 4'b1111;
         OP_SH: begin
            be_lanes    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata_q[15:0]}};
         end
         OP_SB: begin
            be_lanes    = 4'b0001 << addr_q[1:0];
            wdata_lanes = {4{wdata_q[7:0]}};
         end
         default: be_lanes = 4'b0000;
      endcase
   end

   always_comb begin
      half_sel = addr_q[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
      case (addr_q[1:0])
         2'd0:    byte_sel = m_data_rdata[7:0];
         2'd1:    byte_sel = m_data_rdata[15:8];
         2'd2:    byte_sel = m_data_rdata[23:16];
         default: byte_sel = m_data_rdata[31:24];
      endcase
      load_ext = m_data_rdata;
      case (op_q)
         OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_ext = {16'h0000, half_sel};
         OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_ext = {24'h000000, byte_sel};
         default: load_ext = m_data_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      m_data_byteen = 4'b0000;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (fault)               state_nxt = RESP;
               else if (req_op >= OP_SW) state_nxt = STORE;
               else                     state_nxt = LOAD;
            end
         end
         LOAD:  if (mem_ready) state_nxt = RESP;
         STORE: begin
            m_data_byteen = be_lanes;
            if (mem_ready) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         pc_q    <= 32'h0;
         op_q    <= OP_LW;
         rdata_q <= 32'h0;
         exc_q   <= 5'd0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               pc_q    <= req_pc;
               op_q    <= req_op;
               rdata_q <= 32'h0;
               exc_q   <= fault ? fault_code : 5'd0;
            end
            LOAD: if (mem_ready) rdata_q <= load_ext;
            default: ;
         endcase
      end
   end

   assign m_data_addr  = {addr_q[31:2], 2'b00};
   assign m_data_wdata = wdata_lanes;
   assign m_inst_addr  = pc_q;
   assign resp_rdata   = rdata_q;
   assign resp_exc     = exc_q;

`ifdef DM_ACCESS_TRACE_EN
   logic [31:0] merged_word;

   always_comb begin
      merged_word = m_data_rdata;
      for (int b = 0; b < 4; b++)
         if (be_lanes[b]) merged_word[8*b +: 8] = wdata_lanes[8*b +: 8];
   end

   always @(posedge clk) begin
      if (reset) begin
         if (state == STORE && mem_ready)
            $display("@%h: *%h <= %h", m_inst_addr, m_data_addr, merged_word);
         if (state == IDLE && req_valid && fault)
            $display("@%h: exc %d", req_pc, fault_code);
      end
   end
`else
   // Trace disabled: no simulation output from this unit.
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] req_pc = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_exc;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_data_rdata;
   logic        mem_ready = 1'b1;
   logic [31:0] m_inst_addr;

   int n_cmp = 0;
   int n_err = 0;

   logic [36:0] resp_q[$];
   logic [67:0] bus_q[$];

   logic [31:0] mem [16] = '{2: 32'h8000_FF80, default: 32'h0};

   always #5 clk = ~clk;

   dm_access_unit #(.DM_BASE(32'h0000_0000), .DM_WORDS(4096)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_exc(resp_exc),
      .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
      .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
      .mem_ready(mem_ready), .m_inst_addr(m_inst_addr)
   );

   assign m_data_rdata = mem[m_data_addr[5:2]];

   always @(posedge clk)
      if (reset && m_data_byteen != 4'b0000 && mem_ready)
         for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) mem[m_data_addr[5:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expected responses and bus writes as the DUT presents them.
   always @(negedge clk) begin
      logic [36:0] er;
      logic [67:0] eb;
      if (reset) begin
         if (resp_valid && resp_ready) begin
            if (resp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL resp_unexpected: got rdata %h exc %0d expected no response", resp_rdata, resp_exc);
            end else begin
               er = resp_q.pop_front();
               chk("resp_rdata", resp_rdata, er[36:5]);
               chk("resp_exc", {27'd0, resp_exc}, {27'd0, er[4:0]});
            end
         end
         if (m_data_byteen != 4'b0000 && mem_ready) begin
            if (bus_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL bus_unexpected: got byteen %b addr %h expected no write", m_data_byteen, m_data_addr);
            end else begin
               eb = bus_q.pop_front();
               chk("bus_addr", m_data_addr, eb[67:36]);
               chk("bus_byteen", {28'd0, m_data_byteen}, {28'd0, eb[35:32]});
               chk("bus_wdata", m_data_wdata, eb[31:0]);
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] pc, input logic exp_resp,
                       input logic [31:0] exp_rdata, input logic [4:0] exp_exc);
      int t = 0;
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_cmp++; n_err++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
      if (exp_resp) resp_q.push_back({exp_rdata, exp_exc});
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = data; req_pc = pc;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(req_ready && resp_q.size() == 0 && bus_q.size() == 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_cmp++; n_err++;
         $display("FAIL idle_timeout: got %0d pending expected 0", resp_q.size() + bus_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      // reset
      repeat (2) @(negedge clk);
      chk("rst_low_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_low_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_byteen", {28'd0, m_data_byteen}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_m_data_addr", m_data_addr, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);

      // SB with latency checks
      bus_q.push_back({32'h0000_0004, 4'b0010, 32'hABAB_ABAB});
      send(3'd7, 32'h5, 32'hAB, 32'h100, 1'b1, 32'h0, 5'd0);
      @(negedge clk);
      chk("sb_byteen_cycle", {28'd0, m_data_byteen}, 32'h2);
      chk("sb_inst_addr", m_inst_addr, 32'h100);
      chk("sb_req_ready_busy", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("sb_byteen_after", {28'd0, m_data_byteen}, 32'd0);
      @(negedge clk);
      chk("sb_back_idle", {31'd0, req_ready}, 32'd1);

      // loads and extension
      send(3'd3, 32'h8,  32'h0, 32'h104, 1'b1, 32'hFFFF_FF80, 5'd0);
      send(3'd4, 32'h9,  32'h0, 32'h108, 1'b1, 32'h0000_00FF, 5'd0);
      send(3'd1, 32'hA,  32'h0, 32'h10C, 1'b1, 32'hFFFF_8000, 5'd0);
      send(3'd0, 32'h8,  32'h0, 32'h110, 1'b1, 32'h8000_FF80, 5'd0);
      send(3'd4, 32'h5,  32'h0, 32'h114, 1'b1, 32'h0000_00AB, 5'd0);
      send(3'd3, 32'h5,  32'h0, 32'h118, 1'b1, 32'hFFFF_FFAB, 5'd0);

      // faults: no bus writes expected
      send(3'd5, 32'h2,         32'h1234, 32'h120, 1'b1, 32'h0, 5'd5);
      send(3'd1, 32'h3,         32'h0,    32'h124, 1'b1, 32'h0, 5'd4);
      send(3'd0, 32'h4000,      32'h0,    32'h128, 1'b1, 32'h0, 5'd4);
      send(3'd0, 32'hFFFF_FFFC, 32'h0,    32'h12C, 1'b1, 32'h0, 5'd4);
      send(3'd7, 32'h4000,      32'h55,   32'h130, 1'b1, 32'h0, 5'd5);
      send(3'd0, 32'h3FFC,      32'h0,    32'h134, 1'b1, 32'h0, 5'd0);
      wait_idle();

      // SH with mem_ready low for 3 cycles
      mem_ready = 1'b0;
      bus_q.push_back({32'h0000_0010, 4'b0011, 32'h5678_5678});
      send(3'd6, 32'h10, 32'h1234_5678, 32'h200, 1'b1, 32'h0, 5'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("sh_hold_addr", m_data_addr, 32'h10);
         chk("sh_hold_byteen", {28'd0, m_data_byteen}, 32'h3);
         chk("sh_hold_wdata", m_data_wdata, 32'h5678_5678);
         chk("sh_no_resp", {31'd0, resp_valid}, 32'd0);
         if (i == 2) begin
            @(posedge clk);
            #1 mem_ready = 1'b1;
         end
      end
      @(posedge clk); #1;
      chk("sh_resp_valid", {31'd0, resp_valid}, 32'd1);
      send(3'd1, 32'h10, 32'h0, 32'h204, 1'b1, 32'h0000_5678, 5'd0);
      send(3'd2, 32'h12, 32'h0, 32'h208, 1'b1, 32'h0000_0000, 5'd0);
      wait_idle();

      // response backpressure with a second request waiting
      resp_ready = 1'b0;
      send(3'd0, 32'h8, 32'h0, 32'h300, 1'b1, 32'h8000_FF80, 5'd0);
      resp_q.push_back({32'h0000_00FF, 5'd0});
      req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h9; req_pc = 32'h304;
      t = 0;
      while (!resp_valid && t < 20) begin @(negedge clk); t++; end
      chk("bp_resp_seen", {31'd0, resp_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_resp_rdata", resp_rdata, 32'h8000_FF80);
         chk("bp_resp_exc", {27'd0, resp_exc}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      t = 0;
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      chk("bp_accept_after", {30'd0, req_ready, resp_valid}, 32'h2);
      @(posedge clk); #1 req_valid = 1'b0;
      wait_idle();

      // reset during STORE aborts without a response or write
      mem_ready = 1'b0;
      send(3'd5, 32'h20, 32'hDEAD_BEEF, 32'h400, 1'b0, 32'h0, 5'd0);
      @(negedge clk);
      chk("rs_byteen_before", {28'd0, m_data_byteen}, 32'hF);
      #2 reset = 1'b0;
      #1;
      chk("rs_byteen_now", {28'd0, m_data_byteen}, 32'h0);
      chk("rs_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) begin
         @(negedge clk);
         chk("rs_no_resp_low", {31'd0, resp_valid}, 32'd0);
      end
      @(posedge clk); #1 reset = 1'b1; mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rs_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      chk("rs_no_write", mem[8], 32'h0);

      wait_idle();
      chk("resp_q_drained", resp_q.size(), 32'd0);
      chk("bus_q_drained", bus_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
